t5_hart_sched: RTL and testbench
================================

Name: t5_hart_sched

Overview:
- Barrel-thread scheduler for the 4-hart fetch stage.
- Owns the hart rotation and produces the fetch stage's `sena` together with the hart slot code.
- Tracks per-hart run state: HALT, RUN, SLEEP.
- Gates the instruction-bus strobe so that only running harts consume fetch bandwidth. A hung fetch is aborted by a watchdog.

Parameters:
- BOOTMASK, 4'b0001, harts that enter RUN on reset (bit n = hart n).
- TOUT, 15, maximum cycles a strobe may wait for iack before abort (1..255).

Ports:
- sclk  in  1  clock
- srst  in  1  reset, synchronous, active-high
- iack  in  1  instruction bus acknowledge for the current strobe
- hstart  in  4  per-hart start request (HALT->RUN)
- hstop  in  4  per-hart stop request (any->HALT)
- hwake  in  4  per-hart wake event (SLEEP->RUN)
- xwfi  in  1  execute stage retiring a WFI
- xhart  in  2  slot code of the hart retiring in execute
- sena  out  1  fetch-stage advance enable
- fhart  out  2  current slot code, Johnson order 00,01,11,10
- fvld  out  1  current slot carries a real fetch (hart in RUN)
- istb  out  1  instruction bus strobe
- ierr  out  1  one-cycle pulse: fetch watchdog expired
- hrun  out  4  per-hart RUN status
- hslp  out  4  per-hart SLEEP status

Behaviour:
- Slot code to hart index mapping: 00->0, 01->1, 11->2, 10->3.
- xhart uses the same mapping.
- Per-hart state encoding: HALT=0, RUN=1, SLEEP=2; 3 is illegal and recovers to HALT.
- Reset values:
  - fhart=00, ierr=0, watchdog count=0.
  - Hart n state = RUN if BOOTMASK[n], else HALT.
  - Outputs derived from these: fvld=BOOTMASK[0], istb=BOOTMASK[0], sena=1 if hart0 not RUN.
- Combinational outputs:
  - fvld = state[idx(fhart)]==RUN.
  - istb = fvld.
  - sena = ~istb | iack | wdexp, where wdexp = (count==TOUT).
- Slot advance: on posedge, if sena, fhart <= {fhart[0], ~fhart[1]}.
  - Halted or sleeping slots are still visited: bubble, one cycle, no bus traffic. Barrel timing is preserved.
- Watchdog:
  - count increments each cycle while istb & ~iack.
  - count clears when sena=1.
  - Saturates at TOUT.
  - When wdexp: ierr=1 for that cycle, the slot advances, and the slot's hart goes to HALT.
  - iack arriving in the same cycle as wdexp: iack wins, no ierr, hart stays RUN.
- Per-hart transitions, evaluated each cycle; priority highest first:
  1. hstop[n] or watchdog abort on hart n -> HALT.
  2. xwfi & idx(xhart)==n & state==RUN -> SLEEP.
  3. hwake[n] & state==SLEEP -> RUN.
  4. hstart[n] & state==HALT -> RUN.
- Other rules:
  - hstart on a RUN or SLEEP hart: ignored.
  - hwake on a RUN or HALT hart: ignored; it is not latched.
  - xwfi together with hwake for the same hart in the same cycle: SLEEP wins. The wake is lost, and software must re-arm.
- A hart state change takes effect for the next visit of its slot.
  - If the change occurs while its slot is current and stalled, the new state is seen next cycle: a stop drops istb immediately and sena rises.
- hrun[n] and hslp[n] are registered state decodes.
- srst mid-stall: all state returns to reset values in one cycle, any pending strobe is dropped, and no ierr is issued.

Test Plan:
1. Reset, BOOTMASK=0001, iack tied 1 -> fhart cycles 00,01,11,10,00; fvld=1 only at fhart=00; istb high 1 cycle in 4.
2. hstart=4'b1111 pulse, iack=1 -> hrun=1111 next cycle; fvld=1 every cycle; sena constant 1.
3. All harts RUN, iack held 0 at fhart=01 for 3 cycles then 1 -> fhart stays 01 for 4 cycles, sena=0 for 3 cycles, then advances to 11; ierr never set.
4. TOUT=15, iack stuck 0 at hart0 -> ierr pulses on 16th cycle of strobe, fhart advances to 01, hrun[0]=0.
5. xwfi=1, xhart=11 -> hslp=0100, hart2 slot gives fvld=0; hwake[2] pulse -> hrun[2]=1 next cycle.
6. Same-cycle hstop[1] and hstart[1] on a HALT hart -> hart1 stays HALT. srst asserted mid-stall -> fhart=00 and hrun=BOOTMASK next cycle, ierr=0.

Source files
------------

// File: rtl/t5_hart_sched_if.sv
// Fetch-side bus between the barrel scheduler and the fetch stage / instruction bus.
// master = scheduler, slave = fetch stage plus bus (returns iack).
interface t5_hart_sched_if;
    logic       iack;
    logic       sena;
    logic [1:0] fhart;
    logic       fvld;
    logic       istb;
    logic       ierr;

    modport master (
        input  iack,
        output sena,
        output fhart,
        output fvld,
        output istb,
        output ierr
    );

    modport slave (
        output iack,
        input  sena,
        input  fhart,
        input  fvld,
        input  istb,
        input  ierr
    );
endinterface

// File: rtl/t5_hart_sched.sv
// Barrel-thread scheduler for a 4-hart fetch stage: Johnson-coded slot rotation,
// per-hart HALT/RUN/SLEEP tracking, strobe gating and a fetch watchdog.
module t5_hart_sched #(
    parameter logic [3:0]  BOOTMASK = 4'b0001,
    parameter int unsigned TOUT     = 15
) (
    input  logic            sclk,
    input  logic            srst,
    input  logic [3:0]      hstart,
    input  logic [3:0]      hstop,
    input  logic [3:0]      hwake,
    input  logic            xwfi,
    input  logic [1:0]      xhart,
    output logic [3:0]      hrun,
    output logic [3:0]      hslp,
    t5_hart_sched_if.master fbus
);

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SLEEP = 2'd2,
        ST_BAD   = 2'd3
    } hstate_t;

    localparam logic [7:0] TOUT_C = 8'(TOUT);

    hstate_t    st_reg  [4];
    hstate_t    st_next [4];
    logic [1:0] fhart_reg;
    logic [7:0] count_reg;
    logic [1:0] cur_idx;
    logic [1:0] xidx;
    logic       stb;
    logic       wdexp;
    logic       ena;
    logic       abort;

    // Johnson slot code 00,01,11,10 maps to hart 0,1,2,3.
    function automatic logic [1:0] slot_idx(input logic [1:0] code);
        return {code[1], code[1] ^ code[0]};
    endfunction

    // State checks make wfi/wake/start mutually exclusive; stop dominates all.
    function automatic hstate_t hart_next(input hstate_t cur, input logic stop,
                                          input logic wfi, input logic wake,
                                          input logic start);
        hstate_t nxt;
        nxt = cur;
        if (stop) begin
            nxt = ST_HALT;
        end else begin
            case (cur)
                ST_RUN:   if (wfi)   nxt = ST_SLEEP;
                ST_SLEEP: if (wake)  nxt = ST_RUN;
                ST_HALT:  if (start) nxt = ST_RUN;
                default:             nxt = ST_HALT;
            endcase
        end
        return nxt;
    endfunction

    assign cur_idx = slot_idx(fhart_reg);
    assign xidx    = slot_idx(xhart);
    assign stb     = (st_reg[cur_idx] == ST_RUN);
    assign wdexp   = (count_reg == TOUT_C);
    assign ena     = ~stb | fbus.iack | wdexp;
    // A late iack in the expiry cycle still completes the fetch, so no abort.
    assign abort   = stb & ~fbus.iack & wdexp;

    assign fbus.fhart = fhart_reg;
    assign fbus.fvld  = stb;
    assign fbus.istb  = stb;
    assign fbus.sena  = ena;
    assign fbus.ierr  = abort & ~srst;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_hart
            assign st_next[gi] = hart_next(st_reg[gi],
                                           hstop[gi] | (abort & (cur_idx == 2'(gi))),
                                           xwfi & (xidx == 2'(gi)),
                                           hwake[gi],
                                           hstart[gi]);
            assign hrun[gi] = (st_reg[gi] == ST_RUN);
            assign hslp[gi] = (st_reg[gi] == ST_SLEEP);
        end
    endgenerate

    always_ff @(posedge sclk) begin
        if (srst) begin
            fhart_reg <= 2'b00;
            count_reg <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                st_reg[i] <= BOOTMASK[i] ? ST_RUN : ST_HALT;
            end
        end else begin
            if (ena) begin
                fhart_reg <= {fhart_reg[0], ~fhart_reg[1]};
                count_reg <= 8'd0;
            end else if (count_reg != TOUT_C) begin
                count_reg <= count_reg + 8'd1;
            end
            for (int i = 0; i < 4; i++) begin
                st_reg[i] <= st_next[i];
            end
        end
    end

endmodule

// File: tb/tb_t5_hart_sched.sv
// Directed bench for t5_hart_sched: rotation, stalls, watchdog, sleep/wake, stop/start, reset.
module tb_t5_hart_sched;

    logic       sclk = 1'b0;
    logic       srst;
    logic [3:0] hstart;
    logic [3:0] hstop;
    logic [3:0] hwake;
    logic       xwfi;
    logic [1:0] xhart;
    logic [3:0] hrun;
    logic [3:0] hslp;

    int total = 0;
    int bad   = 0;

    t5_hart_sched_if fbus ();

    t5_hart_sched #(
        .BOOTMASK (4'b0001),
        .TOUT     (15)
    ) dut (
        .sclk   (sclk),
        .srst   (srst),
        .hstart (hstart),
        .hstop  (hstop),
        .hwake  (hwake),
        .xwfi   (xwfi),
        .xhart  (xhart),
        .hrun   (hrun),
        .hslp   (hslp),
        .fbus   (fbus)
    );

    always #5 sclk = ~sclk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge sclk);
        #2;
    endtask

    task automatic do_reset();
        srst      = 1'b1;
        hstart    = 4'b0;
        hstop     = 4'b0;
        hwake     = 4'b0;
        xwfi      = 1'b0;
        xhart     = 2'b00;
        fbus.iack = 1'b1;
        step();
        srst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (fbus.fhart !== 2'b00) begin bad++; $display("FAIL reset_fhart got=%b want=00", fbus.fhart); end
        total++; if (fbus.fvld !== 1'b1) begin bad++; $display("FAIL reset_fvld got=%b want=1", fbus.fvld); end
        total++; if (fbus.istb !== 1'b1) begin bad++; $display("FAIL reset_istb got=%b want=1", fbus.istb); end
        total++; if (fbus.ierr !== 1'b0) begin bad++; $display("FAIL reset_ierr got=%b want=0", fbus.ierr); end
        total++; if (hrun !== 4'b0001) begin bad++; $display("FAIL reset_hrun got=%b want=0001", hrun); end
        total++; if (hslp !== 4'b0000) begin bad++; $display("FAIL reset_hslp got=%b want=0000", hslp); end
        total++; if (fbus.sena !== 1'b1) begin bad++; $display("FAIL reset_sena got=%b want=1", fbus.sena); end
        $display("test_reset done");
    endtask

    task automatic test_rotation();
        logic [1:0] exp_f [5];
        logic       exp_v;
        int         strobes;
        exp_f[0] = 2'b00; exp_f[1] = 2'b01; exp_f[2] = 2'b11; exp_f[3] = 2'b10; exp_f[4] = 2'b00;
        strobes = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            exp_v = (i == 0) || (i == 4);
            total++; if (fbus.fhart !== exp_f[i]) begin bad++; $display("FAIL rot_fhart[%0d] got=%b want=%b", i, fbus.fhart, exp_f[i]); end
            total++; if (fbus.fvld !== exp_v) begin bad++; $display("FAIL rot_fvld[%0d] got=%b want=%b", i, fbus.fvld, exp_v); end
            if (i < 4 && fbus.istb === 1'b1) strobes++;
            step(); #1;
        end
        total++; if (strobes != 1) begin bad++; $display("FAIL rot_strobes got=%0d want=1", strobes); end
        $display("test_rotation done");
    endtask

    task automatic test_all_run();
        logic [1:0] exp_f [4];
        exp_f[0] = 2'b01; exp_f[1] = 2'b11; exp_f[2] = 2'b10; exp_f[3] = 2'b00;
        do_reset();
        hstart = 4'b1111;
        step();
        hstart = 4'b0000;
        #1;
        total++; if (hrun !== 4'b1111) begin bad++; $display("FAIL allrun_hrun got=%b want=1111", hrun); end
        for (int i = 0; i < 4; i++) begin
            total++; if (fbus.fhart !== exp_f[i]) begin bad++; $display("FAIL allrun_fhart[%0d] got=%b want=%b", i, fbus.fhart, exp_f[i]); end
            total++; if (fbus.fvld !== 1'b1) begin bad++; $display("FAIL allrun_fvld[%0d] got=%b want=1", i, fbus.fvld); end
            total++; if (fbus.sena !== 1'b1) begin bad++; $display("FAIL allrun_sena[%0d] got=%b want=1", i, fbus.sena); end
            step(); #1;
        end
        $display("test_all_run done");
    endtask

    task automatic test_stall();
        do_reset();
        hstart = 4'b1111;
        step();
        hstart    = 4'b0000;
        fbus.iack = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++; if (fbus.fhart !== 2'b01) begin bad++; $display("FAIL stall_fhart[%0d] got=%b want=01", k, fbus.fhart); end
            total++; if (fbus.sena !== 1'b0) begin bad++; $display("FAIL stall_sena[%0d] got=%b want=0", k, fbus.sena); end
            total++; if (fbus.ierr !== 1'b0) begin bad++; $display("FAIL stall_ierr[%0d] got=%b want=0", k, fbus.ierr); end
            step(); #1;
        end
        fbus.iack = 1'b1;
        #1;
        total++; if (fbus.fhart !== 2'b01) begin bad++; $display("FAIL stall_ack_fhart got=%b want=01", fbus.fhart); end
        total++; if (fbus.sena !== 1'b1) begin bad++; $display("FAIL stall_ack_sena got=%b want=1", fbus.sena); end
        step(); #1;
        total++; if (fbus.fhart !== 2'b11) begin bad++; $display("FAIL stall_adv_fhart got=%b want=11", fbus.fhart); end
        total++; if (hrun !== 4'b1111) begin bad++; $display("FAIL stall_hrun got=%b want=1111", hrun); end
        $display("test_stall done");
    endtask

    task automatic test_watchdog();
        do_reset();
        fbus.iack = 1'b0;
        #1;
        for (int c = 1; c <= 15; c++) begin
            total++; if (fbus.ierr !== 1'b0) begin bad++; $display("FAIL wd_early_ierr[%0d] got=%b want=0", c, fbus.ierr); end
            total++; if (fbus.sena !== 1'b0) begin bad++; $display("FAIL wd_early_sena[%0d] got=%b want=0", c, fbus.sena); end
            step(); #1;
        end
        total++; if (fbus.ierr !== 1'b1) begin bad++; $display("FAIL wd_ierr got=%b want=1", fbus.ierr); end
        total++; if (fbus.sena !== 1'b1) begin bad++; $display("FAIL wd_sena got=%b want=1", fbus.sena); end
        step(); #1;
        total++; if (fbus.fhart !== 2'b01) begin bad++; $display("FAIL wd_fhart got=%b want=01", fbus.fhart); end
        total++; if (hrun !== 4'b0000) begin bad++; $display("FAIL wd_hrun got=%b want=0000", hrun); end
        total++; if (fbus.ierr !== 1'b0) begin bad++; $display("FAIL wd_ierr_after got=%b want=0", fbus.ierr); end
        $display("test_watchdog done");
    endtask

    task automatic test_late_ack();
        do_reset();
        fbus.iack = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            step();
        end
        fbus.iack = 1'b1;
        #1;
        total++; if (fbus.ierr !== 1'b0) begin bad++; $display("FAIL late_ierr got=%b want=0", fbus.ierr); end
        step(); #1;
        total++; if (hrun !== 4'b0001) begin bad++; $display("FAIL late_hrun got=%b want=0001", hrun); end
        total++; if (fbus.fhart !== 2'b01) begin bad++; $display("FAIL late_fhart got=%b want=01", fbus.fhart); end
        $display("test_late_ack done");
    endtask

    task automatic test_sleep_wake();
        do_reset();
        hstart = 4'b1111;
        step();
        hstart = 4'b0000;
        xwfi   = 1'b1;
        xhart  = 2'b11;
        step();
        xwfi = 1'b0;
        fbus.iack = 1'b0;
        #1;
        total++; if (hslp !== 4'b0100) begin bad++; $display("FAIL slp_hslp got=%b want=0100", hslp); end
        total++; if (hrun !== 4'b1011) begin bad++; $display("FAIL slp_hrun got=%b want=1011", hrun); end
        total++; if (fbus.fhart !== 2'b11) begin bad++; $display("FAIL slp_fhart got=%b want=11", fbus.fhart); end
        total++; if (fbus.fvld !== 1'b0) begin bad++; $display("FAIL slp_fvld got=%b want=0", fbus.fvld); end
        total++; if (fbus.sena !== 1'b1) begin bad++; $display("FAIL slp_bubble_sena got=%b want=1", fbus.sena); end
        fbus.iack = 1'b1;
        hwake     = 4'b0100;
        step();
        hwake = 4'b0000;
        #1;
        total++; if (hrun !== 4'b1111) begin bad++; $display("FAIL wake_hrun got=%b want=1111", hrun); end
        total++; if (hslp !== 4'b0000) begin bad++; $display("FAIL wake_hslp got=%b want=0000", hslp); end
        // WFI and wake for hart1 in the same cycle: sleep wins, wake lost.
        xwfi  = 1'b1;
        xhart = 2'b01;
        hwake = 4'b0010;
        step();
        xwfi  = 1'b0;
        hwake = 4'b0000;
        #1;
        total++; if (hslp !== 4'b0010) begin bad++; $display("FAIL wfiwake_hslp got=%b want=0010", hslp); end
        step(); #1;
        total++; if (hslp !== 4'b0010) begin bad++; $display("FAIL wfiwake_nolatch got=%b want=0010", hslp); end
        // Wake on a RUN hart is ignored and not remembered for a later WFI.
        hwake = 4'b0001;
        step();
        hwake = 4'b0000;
        xwfi  = 1'b1;
        xhart = 2'b00;
        step();
        xwfi = 1'b0;
        #1;
        total++; if (hslp !== 4'b0011) begin bad++; $display("FAIL runwake_hslp got=%b want=0011", hslp); end
        $display("test_sleep_wake done");
    endtask

    task automatic test_stop_start();
        do_reset();
        hstop  = 4'b0010;
        hstart = 4'b0010;
        step();
        hstop  = 4'b0000;
        hstart = 4'b0000;
        #1;
        total++; if (hrun !== 4'b0001) begin bad++; $display("FAIL stopstart_hrun got=%b want=0001", hrun); end
        hstart = 4'b0010;
        step();
        hstart = 4'b0000;
        #1;
        total++; if (hrun !== 4'b0011) begin bad++; $display("FAIL start_hrun got=%b want=0011", hrun); end
        // fhart is now 11 (hart2 halted); one more edge reaches hart3, two to hart0.
        step(); step();
        fbus.iack = 1'b0;
        #1;
        total++; if (fbus.fhart !== 2'b00) begin bad++; $display("FAIL stop_pre_fhart got=%b want=00", fbus.fhart); end
        hstop = 4'b0001;
        #1;
        total++; if (fbus.sena !== 1'b0) begin bad++; $display("FAIL stop_same_sena got=%b want=0", fbus.sena); end
        step();
        hstop = 4'b0000;
        #1;
        total++; if (fbus.fhart !== 2'b00) begin bad++; $display("FAIL stop_fhart got=%b want=00", fbus.fhart); end
        total++; if (fbus.istb !== 1'b0) begin bad++; $display("FAIL stop_istb got=%b want=0", fbus.istb); end
        total++; if (fbus.sena !== 1'b1) begin bad++; $display("FAIL stop_sena got=%b want=1", fbus.sena); end
        $display("test_stop_start done");
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        hstart = 4'b1111;
        step();
        hstart    = 4'b0000;
        fbus.iack = 1'b0;
        for (int c = 0; c < 15; c++) begin
            step();
        end
        srst = 1'b1;
        step();
        srst = 1'b0;
        #1;
        total++; if (fbus.fhart !== 2'b00) begin bad++; $display("FAIL rststall_fhart got=%b want=00", fbus.fhart); end
        total++; if (hrun !== 4'b0001) begin bad++; $display("FAIL rststall_hrun got=%b want=0001", hrun); end
        total++; if (fbus.ierr !== 1'b0) begin bad++; $display("FAIL rststall_ierr got=%b want=0", fbus.ierr); end
        total++; if (fbus.sena !== 1'b0) begin bad++; $display("FAIL rststall_count_sena got=%b want=0", fbus.sena); end
        step(); #1;
        total++; if (fbus.ierr !== 1'b0) begin bad++; $display("FAIL rststall_ierr2 got=%b want=0", fbus.ierr); end
        $display("test_reset_mid_stall done");
    endtask

    initial begin
        srst      = 1'b1;
        hstart    = 4'b0;
        hstop     = 4'b0;
        hwake     = 4'b0;
        xwfi      = 1'b0;
        xhart     = 2'b00;
        fbus.iack = 1'b1;
        step();
        test_reset();
        test_rotation();
        test_all_run();
        test_stall();
        test_watchdog();
        test_late_ack();
        test_sleep_wake();
        test_stop_start();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
